// File: rtl/mealy_fsm.sv
// Non-overlapping Mealy detector for the serial pattern 1,0,1,0,1 (oldest first).
// dataout is combinational from the state register and datain.
module mealy_fsm (
  input  logic clk,
  input  logic rst,
  input  logic datain,
  output logic dataout
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    dataout = 1'b0;
    case (state_q)
      S0:    state_d = datain ? S1   : S0;
      S1:    state_d = datain ? S1   : S10;
      S10:   state_d = datain ? S101 : S0;
      S101:  state_d = datain ? S1   : S1010;
      // A completed match restarts from S0 so no matched bit is reused.
      S1010: begin
        state_d = S0;
        dataout = datain & ~rst;
      end
      default: state_d = S0;
    endcase
  end

endmodule

// File: tb/tb_mealy_fsm.sv
// Directed-vector bench for mealy_fsm; each applied bit is checked against a
// hand-computed expected dataout.
module tb_mealy_fsm;

  logic clk;
  logic rst;
  logic datain;
  logic dataout;

  int n_checks;
  int n_errors;

  mealy_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: dataout=%b expected=%b", tag, got, exp);
    end else begin
      $display("ok   %s: dataout=%b", tag, got);
    end
  endtask

  // Called 1 time unit after a rising edge; drives one bit, checks, advances.
  task automatic step(input string tag, input logic d, input logic exp);
    datain = d;
    #2;
    check_bit(tag, dataout, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    datain = 1'b0;
    #2;
    check_bit({tag, "_rst"}, dataout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // bits/exp are strings of '0'/'1', first character applied first.
  task automatic run_seq(input string tag, input string bits, input string exp);
    for (int i = 0; i < bits.len(); i++) begin
      step($sformatf("%s[%0d]", tag, i + 1), bits.getc(i) == "1", exp.getc(i) == "1");
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    datain   = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_bit("reset_state", dataout, 1'b0);
    rst = 1'b0;

    // Reach S1010, then reset with datain=1: output must stay forced low.
    run_seq("pre_rst", "1010", "0000");
    rst    = 1'b1;
    datain = 1'b1;
    #2;
    check_bit("rst_forces_low", dataout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq("after_rst_ones", "111", "000");

    do_reset("single");
    run_seq("single", "101010", "000010");

    do_reset("nonovl");
    run_seq("nonovl", "01101010100", "00000010000");

    do_reset("b2b");
    run_seq("b2b", "1010110101", "0000100001");

    do_reset("prefix");
    run_seq("prefix", "11010010101", "00000000001");

    do_reset("s101_to_s1");
    run_seq("s101_to_s1", "10110101", "00000001");

    do_reset("s10_to_s0");
    run_seq("s10_to_s0", "10010101", "00000001");

    // Mid-sequence reset discards the 1010 prefix.
    do_reset("mid");
    run_seq("mid_a", "1010", "0000");
    do_reset("mid");
    run_seq("mid_b", "10101", "00001");
    run_seq("mid_tail", "0", "0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
